asg_burst_ch_gen: RTL

//  Parametrised arbitrary-signal-generator channel: table RAM, fixed-point read pointer, burst FSM
//  (cycles / repetitions / inter-burst delay), scale+offset with saturation to the DAC.

---
 rtl/asg_burst_ch_gen.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/asg_burst_ch_gen.sv
// Arbitrary-signal-generator channel: sample table RAM, fixed-point read
// pointer, burst sequencer (periods / repetitions / inter-burst delay) and
// a scale + offset stage that saturates to the DAC width.
// One instance per DAC channel, single clock domain (dac_clk_i).
module asg_burst_ch_gen #(
    parameter int DW       = 14,
    parameter int RSZ      = 14,
    parameter int FRAC     = 16,
    parameter int TICK_DIV = 125,
    parameter int DEB_CYC  = 62500
) (
    input  logic                dac_clk_i,
    input  logic                dac_rst_i,
    input  logic                trig_sw_i,
    input  logic                trig_ext_i,
    input  logic [2:0]          trig_src_i,
    output logic                trig_done_o,
    input  logic                buf_we_i,
    input  logic [RSZ-1:0]      buf_addr_i,
    input  logic [DW-1:0]       buf_wdata_i,
    output logic [DW-1:0]       buf_rdata_o,
    output logic [RSZ-1:0]      buf_rpnt_o,
    input  logic [RSZ+FRAC-1:0] set_size_i,
    input  logic [RSZ+FRAC-1:0] set_step_i,
    input  logic [RSZ+FRAC-1:0] set_ofs_i,
    input  logic                set_wrap_i,
    input  logic [DW-1:0]       set_amp_i,
    input  logic [DW-1:0]       set_dc_i,
    input  logic [DW-1:0]       set_last_i,
    input  logic                set_zero_i,
    input  logic                set_rst_i,
    input  logic [15:0]         set_ncyc_i,
    input  logic [15:0]         set_rnum_i,
    input  logic [31:0]         set_rdly_i,
    output logic [DW-1:0]       dac_o,
    output logic [1:0]          state_o,
    output logic [15:0]         burst_cnt_o
);

    localparam int PW  = RSZ + FRAC;
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DBW = $clog2(DEB_CYC + 1);

    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DEB_LOAD  = DBW'(DEB_CYC);
    // Wrap threshold is size + 1.0, so the table period is size + 1.0 in
    // pointer units and a wrap carries the exact fractional remainder.
    localparam logic [PW+1:0]  ONE_FX    = (PW+2)'(1) << FRAC;
    localparam logic [DW-1:0]  SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]  SAT_MIN   = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DELAY = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Trigger path
    // ------------------------------------------------------------------
    logic           ext_s1, ext_s2, ext_s3;
    logic [DBW-1:0] deb_cnt;
    logic           ext_hit, ext_acc, trig_sel, trig_in_q;

    assign ext_hit  = ((trig_src_i == 3'd2) &&  ext_s2 && !ext_s3) ||
                      ((trig_src_i == 3'd3) && !ext_s2 &&  ext_s3);
    assign ext_acc  = ext_hit && (deb_cnt == '0);
    assign trig_sel = ((trig_src_i == 3'd1) && trig_sw_i) || ext_acc;

    // Sync the external trigger, debounce accepted edges and register the
    // selected trigger; an abort kills a trigger arriving in the same clk.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            ext_s1    <= 1'b0;
            ext_s2    <= 1'b0;
            ext_s3    <= 1'b0;
            deb_cnt   <= '0;
            trig_in_q <= 1'b0;
        end else begin
            ext_s1    <= trig_ext_i;
            ext_s2    <= ext_s1;
            ext_s3    <= ext_s2;
            if (ext_acc)
                deb_cnt <= DEB_LOAD;
            else if (deb_cnt != '0)
                deb_cnt <= deb_cnt - 1'b1;
            trig_in_q <= trig_sel && !set_rst_i;
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM and read pointer
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PW-1:0]   pnt_q, pnt_d;
    logic [15:0]     cyc_q, cyc_d, rep_q, rep_d, bcnt_q, bcnt_d;
    logic [31:0]     dly_q, dly_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            done_d;
    logic [PW:0]     nxt_sum;
    logic [PW+1:0]   diff;
    logic            wrap_hit, tick_last;

    assign nxt_sum   = {1'b0, pnt_q} + {1'b0, set_step_i};
    assign diff      = {1'b0, nxt_sum} - {2'b0, set_size_i} - ONE_FX;
    assign wrap_hit  = !diff[PW+1];
    assign tick_last = (tick_q == TICK_LAST);

    // Next state, pointer and counters; abort has top priority.
    always_comb begin
        state_d = state_q;
        pnt_d   = pnt_q;
        cyc_d   = cyc_q;
        rep_d   = rep_q;
        dly_d   = dly_q;
        tick_d  = tick_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        if (set_rst_i) begin
            state_d = ST_IDLE;
            pnt_d   = set_ofs_i;
            cyc_d   = '0;
            rep_d   = '0;
            dly_d   = '0;
            tick_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (trig_in_q) begin
                        state_d = ST_RUN;
                        pnt_d   = set_ofs_i;
                        cyc_d   = set_ncyc_i;
                        rep_d   = (set_rnum_i == 16'd0) ? 16'd1 : set_rnum_i;
                        bcnt_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wrap_hit) begin
                        pnt_d = set_wrap_i ? diff[PW-1:0] : set_ofs_i;
                        // cyc == 0 marks continuous mode and never counts down
                        if (cyc_q == 16'd1) begin
                            bcnt_d = bcnt_q + 16'd1;
                            rep_d  = rep_q - 16'd1;
                            if (rep_q == 16'd1) begin
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_DELAY;
                                dly_d   = set_rdly_i;
                                tick_d  = '0;
                            end
                        end else if (cyc_q != 16'd0) begin
                            cyc_d = cyc_q - 16'd1;
                        end
                    end else begin
                        pnt_d = nxt_sum[PW-1:0];
                    end
                end
                ST_DELAY: begin
                    // Leaving on the tick that would reach zero makes N ticks
                    // last exactly N*TICK_DIV clks; zero ticks last one clk.
                    if ((dly_q == 32'd0) || ((dly_q == 32'd1) && tick_last)) begin
                        state_d = ST_RUN;
                        pnt_d   = set_ofs_i;
                        cyc_d   = set_ncyc_i;
                    end else if (tick_last) begin
                        tick_d = '0;
                        dly_d  = dly_q - 32'd1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, pointer and counter registers.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q     <= ST_IDLE;
            pnt_q       <= '0;
            cyc_q       <= '0;
            rep_q       <= '0;
            dly_q       <= '0;
            tick_q      <= '0;
            bcnt_q      <= '0;
            trig_done_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            pnt_q       <= pnt_d;
            cyc_q       <= cyc_d;
            rep_q       <= rep_d;
            dly_q       <= dly_d;
            tick_q      <= tick_d;
            bcnt_q      <= bcnt_d;
            trig_done_o <= done_d;
        end
    end

    assign state_o     = state_q;
    assign buf_rpnt_o  = pnt_q[PW-1:FRAC];
    assign burst_cnt_o = bcnt_q;

    // ------------------------------------------------------------------
    // Table RAM and 5-stage output datapath
    // ------------------------------------------------------------------
    logic [DW-1:0]        ram [2**RSZ];
    logic [RSZ-1:0]       rd_addr_q;
    logic signed [DW-1:0] ram_q;
    logic [DW-1:0]        rdata_q;
    logic signed [DW:0]   amp_ext;
    logic signed [2*DW:0] prod;
    logic [DW:0]          mul_q;
    logic [DW+1:0]        sum_d, sum_q;
    logic [2:0]           sum_top;
    logic [DW-1:0]        sat_val;
    logic [3:0]           hold_p;
    logic                 unused_bits;

    // Table write port; contents survive reset.
    always_ff @(posedge dac_clk_i) begin
        if (buf_we_i)
            ram[buf_addr_i] <= buf_wdata_i;
    end

    assign amp_ext = {1'b0, set_amp_i};
    assign prod    = ram_q * amp_ext;
    // One guard bit above DW+1 so full gain plus offset cannot wrap.
    assign sum_d   = {mul_q[DW], mul_q} + {{2{set_dc_i[DW-1]}}, set_dc_i};
    assign sum_top = sum_q[DW+1:DW-1];

    assign unused_bits = &{1'b0, prod[2*DW], prod[DW-2:0], diff[PW]};

    // Saturate the offset sum to the signed DAC range.
    always_comb begin
        sat_val = sum_q[DW-1:0];
        if ((sum_top != 3'b000) && (sum_top != 3'b111))
            sat_val = sum_q[DW+1] ? SAT_MIN : SAT_MAX;
    end

    // Address, RAM read, multiply, add, saturate; the HOLD flag travels
    // alongside so the final burst sample is emitted before the last value.
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            rd_addr_q <= '0;
            ram_q     <= '0;
            rdata_q   <= '0;
            mul_q     <= '0;
            sum_q     <= '0;
            hold_p    <= '0;
            dac_o     <= '0;
        end else begin
            rd_addr_q <= pnt_q[PW-1:FRAC];
            ram_q     <= ram[rd_addr_q];
            rdata_q   <= ram[buf_addr_i];
            mul_q     <= prod[2*DW-1:DW-1];
            sum_q     <= sum_d;
            hold_p    <= {hold_p[2:0], state_q == ST_HOLD};
            if (set_zero_i)
                dac_o <= '0;
            else if (hold_p[3])
                dac_o <= set_last_i;
            else
                dac_o <= sat_val;
        end
    end

    assign buf_rdata_o = rdata_q;

endmodule
